// File: rtl/en_tick_gen_if.sv
// Control/status bundle between a sequencer and the enable-tick generator.
// The sequencer (master) requests runs and watches the tick/busy/done outputs;
// the generator (slave) consumes the requests and produces them.
interface en_tick_gen_if #(
  parameter int DIV_W   = 8,
  parameter int BURST_W = 4
);
  logic               i_start;
  logic               i_stop;
  logic               i_mode;
  logic [DIV_W-1:0]   i_div;
  logic [BURST_W-1:0] i_burst_len;
  logic               o_tick;
  logic               o_busy;
  logic               o_done;

  modport master (
    output i_start, i_stop, i_mode, i_div, i_burst_len,
    input  o_tick, o_busy, o_done
  );

  modport slave (
    input  i_start, i_stop, i_mode, i_div, i_burst_len,
    output o_tick, o_busy, o_done
  );
endinterface

// File: rtl/en_tick_gen.sv
// Programmable enable-pulse generator for the 4-bit counter stage.
// Divides i_clk by (div+1) and emits single-cycle ticks, either continuously
// or as a burst of (burst_len+1) ticks followed by a one-cycle done pulse.
// All outputs decode registers only, so there is no input-to-output path.
module en_tick_gen #(
  parameter int DIV_W   = 8,
  parameter int BURST_W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  en_tick_gen_if.slave bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               mode_q, mode_d;
  logic [BURST_W-1:0] len_q, len_d;
  logic               done_q, done_d;

  logic tick_hit;
  logic last_tick;

  // Tick is a pure register decode; an async reset of state_q drops it at once.
  assign tick_hit  = (state_q == ST_RUN) && (div_cnt_q == div_q);
  assign last_tick = tick_hit && mode_q && (burst_cnt_q == len_q);

  // Next-state and counter update for the IDLE/RUN controller.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // (which would otherwise infer a latch).
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    burst_cnt_d = burst_cnt_q;
    div_d       = div_q;
    mode_d      = mode_q;
    len_d       = len_q;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Stop has priority; a simultaneous start/stop leaves us idle.
        if (bus.i_start && !bus.i_stop) begin
          state_d     = ST_RUN;
          div_d       = bus.i_div;
          mode_d      = bus.i_mode;
          len_d       = bus.i_burst_len;
          div_cnt_d   = '0;
          burst_cnt_d = '0;
        end
      end

      ST_RUN: begin
        // Divider wraps at div_q so div_cnt never exceeds it.
        div_cnt_d = tick_hit ? '0 : div_cnt_q + DIV_W'(1);

        if (bus.i_stop) begin
          // Abort: the tick visible this cycle (if any) has already been
          // delivered; nothing follows and no done pulse is raised.
          state_d     = ST_IDLE;
          div_cnt_d   = '0;
          burst_cnt_d = '0;
        end else if (last_tick) begin
          state_d     = ST_IDLE;
          burst_cnt_d = '0;
          done_d      = 1'b1;
        end else if (tick_hit && mode_q) begin
          // Burst counter only moves in burst mode, so it stays bounded by
          // len_q and is inert in continuous mode.
          burst_cnt_d = burst_cnt_q + BURST_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters, shadow settings and the registered done pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      div_cnt_q   <= '0;
      burst_cnt_q <= '0;
      div_q       <= '0;
      mode_q      <= 1'b0;
      len_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values regardless of statement order.
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      div_q       <= div_d;
      mode_q      <= mode_d;
      len_q       <= len_d;
      done_q      <= done_d;
    end
  end

  assign bus.o_tick = tick_hit;
  assign bus.o_busy = (state_q == ST_RUN);
  assign bus.o_done = done_q;

endmodule

// File: tb/tb_en_tick_gen.sv
// Self-checking bench for en_tick_gen. Stimulus tasks push the expected
// tick/done events (kind + absolute cycle) into a queue; a monitor pops and
// compares each time the DUT raises o_tick or o_done.
module tb_en_tick_gen;

  localparam int DIV_W   = 8;
  localparam int BURST_W = 4;

  typedef enum int { EV_TICK = 0, EV_DONE = 1 } ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       cyc;
  } ev_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   start_cyc;
  int   n_tests;
  int   n_fail;
  ev_t  exp_q[$];
  logic cnt_clr;
  logic [3:0] cnt4;

  en_tick_gen_if #(.DIV_W(DIV_W), .BURST_W(BURST_W)) bus ();

  en_tick_gen #(.DIV_W(DIV_W), .BURST_W(BURST_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the downstream 4-bit counter driven by o_tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt4 <= 4'd0;
    else if (cnt_clr) cnt4 <= 4'd0;
    else if (bus.o_tick) cnt4 <= cnt4 + 4'd1;
  end

  task automatic check(input string name, input int actual, input int expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic handle_event(input ev_kind_e kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL spurious_%s: got event at cycle %0d, expected none",
               (kind == EV_TICK) ? "tick" : "done", cyc);
    end else begin
      e = exp_q.pop_front();
      check("ev_kind", int'(kind), int'(e.kind));
      check("ev_cycle", cyc, e.cyc);
    end
  endtask

  // Monitor: sample outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (bus.o_tick === 1'b1) handle_event(EV_TICK);
    if (bus.o_done === 1'b1) handle_event(EV_DONE);
  end

  // Issue a start; cycle 0 of the run is cycle start_cyc. Pushes n_ticks
  // expected ticks at div, 2*div+1, ... and optionally the done pulse.
  // Returns at the falling edge inside cycle 0.
  task automatic start_run(input bit mode, input int div, input int len,
                           input int n_ticks, input bit with_done);
    ev_t e;
    @(negedge clk);
    bus.i_start     = 1'b1;
    bus.i_mode      = mode;
    bus.i_div       = DIV_W'(div);
    bus.i_burst_len = BURST_W'(len);
    cnt_clr         = 1'b1;
    start_cyc       = cyc + 1;
    for (int k = 0; k < n_ticks; k++) begin
      e.kind = EV_TICK;
      e.cyc  = start_cyc + k * (div + 1) + div;
      exp_q.push_back(e);
    end
    if (with_done) begin
      e.kind = EV_DONE;
      e.cyc  = start_cyc + n_ticks * (div + 1);
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus.i_start = 1'b0;
    cnt_clr     = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    cnt_clr = 1'b0;
    bus.i_start     = 1'b0;
    bus.i_stop      = 1'b0;
    bus.i_mode      = 1'b0;
    bus.i_div       = '0;
    bus.i_burst_len = '0;
    idle_cycles(3);
    rst_n = 1'b1;
    idle_cycles(1);
    check("reset_tick", bus.o_tick, 0);
    check("reset_busy", bus.o_busy, 0);
    check("reset_done", bus.o_done, 0);

    // 1: continuous, div=3 -> ticks in cycles 3,7,11,15; stop sampled at edge 16.
    start_run(1'b0, 3, 0, 4, 1'b0);
    idle_cycles(15);                      // now in cycle 15
    check("t1_busy_c15", bus.o_busy, 1);
    bus.i_stop = 1'b1;
    idle_cycles(1);                       // cycle 16
    bus.i_stop = 1'b0;
    check("t1_busy_after_stop", bus.o_busy, 0);
    idle_cycles(8);
    check("t1_all_events", exp_q.size(), 0);

    // 2: burst, div=1, len=3 -> ticks 1,3,5,7; done and !busy in cycle 8.
    start_run(1'b1, 1, 3, 4, 1'b1);
    idle_cycles(7);                       // cycle 7
    check("t2_busy_c7", bus.o_busy, 1);
    idle_cycles(1);                       // cycle 8
    check("t2_done_c8", bus.o_done, 1);
    check("t2_busy_c8", bus.o_busy, 0);
    idle_cycles(1);
    check("t2_done_c9", bus.o_done, 0);
    idle_cycles(4);
    check("t2_all_events", exp_q.size(), 0);

    // 3: burst, div=0, len=15 -> ticks 0..15; counter wraps; done in cycle 16.
    start_run(1'b1, 0, 15, 16, 1'b1);
    idle_cycles(15);                      // cycle 15
    check("t3_cnt_c15", int'(cnt4), 15);
    check("t3_busy_c15", bus.o_busy, 1);
    idle_cycles(1);                       // cycle 16
    check("t3_cnt_wrap", int'(cnt4), 0);
    check("t3_done_c16", bus.o_done, 1);
    check("t3_busy_c16", bus.o_busy, 0);
    idle_cycles(4);
    check("t3_all_events", exp_q.size(), 0);

    // 4: continuous, div=2; stop sampled at the end of tick cycle 5 ->
    //    ticks only in cycles 2 and 5, idle from cycle 6, no done.
    start_run(1'b0, 2, 0, 2, 1'b0);
    idle_cycles(5);                       // cycle 5 (tick visible)
    bus.i_stop = 1'b1;
    check("t4_busy_c5", bus.o_busy, 1);
    idle_cycles(1);                       // cycle 6
    bus.i_stop = 1'b0;
    check("t4_busy_c6", bus.o_busy, 0);
    idle_cycles(8);
    check("t4_all_events", exp_q.size(), 0);

    // 5a: start and stop together in IDLE -> stays IDLE.
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_stop  = 1'b1;
    bus.i_div   = DIV_W'(0);
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_stop  = 1'b0;
    check("t5_start_stop_busy", bus.o_busy, 0);
    idle_cycles(3);
    check("t5_still_idle", bus.o_busy, 0);

    // 5b: continuous div=2; a start with new div/mode/len during RUN is ignored,
    //     so ticks stay at 2,5,8,11 and no burst-end occurs.
    start_run(1'b0, 2, 0, 4, 1'b0);
    idle_cycles(1);                       // cycle 1
    bus.i_start     = 1'b1;
    bus.i_div       = DIV_W'(7);
    bus.i_mode      = 1'b1;
    bus.i_burst_len = BURST_W'(0);
    idle_cycles(1);                       // cycle 2
    bus.i_start = 1'b0;
    idle_cycles(9);                       // cycle 11
    check("t5_busy_c11", bus.o_busy, 1);
    bus.i_stop = 1'b1;
    idle_cycles(1);                       // cycle 12
    bus.i_stop = 1'b0;
    check("t5_busy_c12", bus.o_busy, 0);
    idle_cycles(6);
    check("t5_all_events", exp_q.size(), 0);

    // 6: burst div=1 len=7; async reset right after the 2nd tick (cycle 3),
    //    then a fresh start must replay all 8 ticks and done.
    start_run(1'b1, 1, 7, 2, 1'b0);
    idle_cycles(3);                       // cycle 3, 2nd tick visible
    #2 rst_n = 1'b0;
    #1;
    check("t6_tick_in_reset", bus.o_tick, 0);
    check("t6_busy_in_reset", bus.o_busy, 0);
    check("t6_done_in_reset", bus.o_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check("t6_events_before_reset", exp_q.size(), 0);
    start_run(1'b1, 1, 7, 8, 1'b1);
    idle_cycles(16);                      // cycle 16
    check("t6_done_c16", bus.o_done, 1);
    check("t6_busy_c16", bus.o_busy, 0);
    check("t6_cnt_after_burst", int'(cnt4), 8);
    idle_cycles(4);
    check("t6_all_events", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
